cpu_sequencer: RTL and testbench

Multi-cycle control sequencer for the 9-bit accumulator-style core. It walks each instruction through fetch, execute, optional memory access and write-back, and drives the enables for the program counter, instruction register, register file and data memory. It sits between the top-level Start/Ack handshake and the combinational decode/write-back mux, which continues to supply `BranchEn` and the register write value.

---
 rtl/cpu_sequencer.sv | 168 ++++++++++++++++
 tb/tb_cpu_sequencer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle control FSM for the 9-bit accumulator core.
// Walks each instruction through FETCH -> EXEC -> (MEM) -> WB and drives the
// PC / IR / register-file / data-memory enables. HALT holds Ack until the next
// Start, which restarts the program.
// Optional feature: define SEQ_PERF_CNT_EN to build the saturating cycle and
// retired-instruction counters; otherwise CycleCnt/InstrCnt read as zero.

module cpu_sequencer #(
  parameter int MEM_LAT = 1  // data-memory latency in cycles, 1..15
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [3:0]  Opcode,
  input  logic        BranchEn,
  output logic        PcInit,
  output logic        IrLoad,
  output logic        PcEn,
  output logic        PcBranch,
  output logic        RegWrEn,
  output logic        MemRdEn,
  output logic        MemWrEn,
  output logic        Ack,
  output logic [15:0] CycleCnt,
  output logic [15:0] InstrCnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  localparam logic [3:0] OP_LDB  = 4'b1000;
  localparam logic [3:0] OP_STB  = 4'b1001;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_HALT = 4'b1111;

  // MEM is entered with the counter preloaded so the enables stay up for
  // exactly MEM_LAT cycles (count down to zero, then leave).
  localparam logic [3:0] WAIT_INIT = 4'(MEM_LAT - 1);

  state_t     state, state_nxt;
  logic [3:0] wait_cnt, wait_nxt;

  logic is_ldb, is_stb, is_jmp, is_halt;

  assign is_ldb  = (Opcode == OP_LDB);
  assign is_stb  = (Opcode == OP_STB);
  assign is_jmp  = (Opcode == OP_JMP);
  assign is_halt = (Opcode == OP_HALT);

  // State and memory-wait counter registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  // Next-state and output decode; only PcInit and PcBranch look at inputs
  // other than state/Opcode.
  always_comb begin
    // NOTE: every output gets a default before the case so no path can leave
    // a signal unassigned and infer a latch.
    state_nxt = state;
    wait_nxt  = wait_cnt;
    PcInit    = 1'b0;
    IrLoad    = 1'b0;
    PcEn      = 1'b0;
    PcBranch  = 1'b0;
    RegWrEn   = 1'b0;
    MemRdEn   = 1'b0;
    MemWrEn   = 1'b0;
    Ack       = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (Start) begin
          PcInit    = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        IrLoad    = 1'b1;
        state_nxt = S_EXEC;
      end
      S_EXEC: begin
        if (is_halt) begin
          state_nxt = S_HALT;
        end else if (is_ldb || is_stb) begin
          state_nxt = S_MEM;
          wait_nxt  = WAIT_INIT;
        end else begin
          state_nxt = S_WB;
        end
      end
      S_MEM: begin
        MemRdEn = is_ldb;
        MemWrEn = is_stb;
        if (wait_cnt == 4'd0) begin
          state_nxt = S_WB;
        end else begin
          wait_nxt = wait_cnt - 4'd1;
        end
      end
      S_WB: begin
        PcEn      = 1'b1;
        RegWrEn   = !(is_stb || is_jmp);
        PcBranch  = is_jmp && BranchEn;
        state_nxt = S_FETCH;
      end
      S_HALT: begin
        Ack = 1'b1;
        if (Start) begin
          PcInit    = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // Reset wins over Start: no PC load while reset is asserted.
    if (Reset) begin
      PcInit = 1'b0;
    end
  end

`ifdef SEQ_PERF_CNT_EN
  logic [15:0] cycle_q, instr_q;
  logic        busy, instr_tick;

  assign busy       = (state == S_FETCH) || (state == S_EXEC) ||
                      (state == S_MEM)   || (state == S_WB);
  assign instr_tick = (state == S_WB) ||
                      ((state == S_EXEC) && (state_nxt == S_HALT));

  // Saturating performance counters, cleared on reset and on program (re)start.
  always_ff @(posedge Clk) begin
    if (Reset || PcInit) begin
      cycle_q <= '0;
      instr_q <= '0;
    end else begin
      if (busy && (cycle_q != 16'hFFFF)) begin
        cycle_q <= cycle_q + 16'd1;
      end
      if (instr_tick && (instr_q != 16'hFFFF)) begin
        instr_q <= instr_q + 16'd1;
      end
    end
  end

  assign CycleCnt = cycle_q;
  assign InstrCnt = instr_q;
`else
  assign CycleCnt = 16'h0000;
  assign InstrCnt = 16'h0000;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed self-checking bench for cpu_sequencer.
// Two instances share clock, reset, Opcode and BranchEn: dut1 (MEM_LAT=1)
// runs the program sequences, dut3 (MEM_LAT=3) runs the long-latency load and
// the mid-MEM reset. Each has its own Start so only one runs at a time.
// Counter expectations follow SEQ_PERF_CNT_EN (zero when undefined).

module tb_cpu_sequencer;

`ifdef SEQ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [3:0] MOV  = 4'b0001;
  localparam logic [3:0] LDH  = 4'b0010;
  localparam logic [3:0] LDB  = 4'b1000;
  localparam logic [3:0] STB  = 4'b1001;
  localparam logic [3:0] JMP  = 4'b1100;
  localparam logic [3:0] HLT  = 4'b1111;

  // Output vector: {PcInit, IrLoad, PcEn, PcBranch, RegWrEn, MemRdEn, MemWrEn, Ack}
  localparam logic [15:0] O_NONE = 16'h00;
  localparam logic [15:0] O_PCI  = 16'h80;
  localparam logic [15:0] O_IRL  = 16'h40;
  localparam logic [15:0] O_WBR  = 16'h28;  // PcEn + RegWrEn
  localparam logic [15:0] O_WBN  = 16'h20;  // PcEn only
  localparam logic [15:0] O_WBJ  = 16'h30;  // PcEn + PcBranch
  localparam logic [15:0] O_RD   = 16'h04;
  localparam logic [15:0] O_WR   = 16'h02;
  localparam logic [15:0] O_ACK  = 16'h01;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       start1, start3;
  logic [3:0] Opcode;
  logic       BranchEn;

  logic        pci1, irl1, pce1, pcb1, rwe1, mre1, mwe1, ack1;
  logic        pci3, irl3, pce3, pcb3, rwe3, mre3, mwe3, ack3;
  logic [15:0] cyc1, ins1, cyc3, ins3;

  logic [15:0] v1, v3;

  int compared   = 0;
  int mismatched = 0;

  always #5 Clk = ~Clk;

  cpu_sequencer #(.MEM_LAT(1)) dut1 (
    .Clk(Clk), .Reset(Reset), .Start(start1), .Opcode(Opcode), .BranchEn(BranchEn),
    .PcInit(pci1), .IrLoad(irl1), .PcEn(pce1), .PcBranch(pcb1), .RegWrEn(rwe1),
    .MemRdEn(mre1), .MemWrEn(mwe1), .Ack(ack1), .CycleCnt(cyc1), .InstrCnt(ins1)
  );

  cpu_sequencer #(.MEM_LAT(3)) dut3 (
    .Clk(Clk), .Reset(Reset), .Start(start3), .Opcode(Opcode), .BranchEn(BranchEn),
    .PcInit(pci3), .IrLoad(irl3), .PcEn(pce3), .PcBranch(pcb3), .RegWrEn(rwe3),
    .MemRdEn(mre3), .MemWrEn(mwe3), .Ack(ack3), .CycleCnt(cyc3), .InstrCnt(ins3)
  );

  assign v1 = {8'h00, pci1, irl1, pce1, pcb1, rwe1, mre1, mwe1, ack1};
  assign v3 = {8'h00, pci3, irl3, pce3, pcb3, rwe3, mre3, mwe3, ack3};

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock, then drive this cycle's inputs and let them settle.
  task automatic cyc(input logic rst, input logic s1, input logic s3,
                     input logic [3:0] op, input logic br);
    @(posedge Clk);
    #1;
    Reset    = rst;
    start1   = s1;
    start3   = s3;
    Opcode   = op;
    BranchEn = br;
    #1;
  endtask

  initial begin
    Reset    = 1'b1;
    start1   = 1'b1;
    start3   = 1'b1;
    Opcode   = 4'h0;
    BranchEn = 1'b0;

    // Reset with Start high: outputs quiet, PcInit suppressed, counters zero.
    cyc(1, 1, 1, 4'h0, 0);
    cyc(1, 1, 1, 4'h0, 0);
    check("rst_out1", v1, O_NONE);
    check("rst_out3", v3, O_NONE);
    check("rst_cyc1", cyc1, 16'd0);
    check("rst_ins1", ins1, 16'd0);

    cyc(0, 0, 0, 4'h0, 0);
    check("idle_no_start", v1, O_NONE);

    // Program {mov, ldh, halt} on dut1.
    cyc(0, 1, 0, 4'h0, 0); check("c0_pcinit", v1, O_PCI);
    cyc(0, 0, 0, MOV, 0);  check("c1_fetch", v1, O_IRL);
    cyc(0, 0, 0, MOV, 0);  check("c2_exec", v1, O_NONE);
    cyc(0, 0, 0, MOV, 0);  check("c3_wb", v1, O_WBR);
    cyc(0, 0, 0, LDH, 0);  check("c4_fetch", v1, O_IRL);
    cyc(0, 0, 0, LDH, 0);  check("c5_exec", v1, O_NONE);
    cyc(0, 0, 0, LDH, 0);  check("c6_wb", v1, O_WBR);
    cyc(0, 0, 0, HLT, 0);  check("c7_fetch", v1, O_IRL);
    cyc(0, 0, 0, HLT, 0);  check("c8_exec", v1, O_NONE);
    cyc(0, 0, 0, HLT, 0);  check("c9_halt", v1, O_ACK);
    check("prog_cyc", cyc1, PERF ? 16'd8 : 16'd0);
    check("prog_ins", ins1, PERF ? 16'd3 : 16'd0);
    cyc(0, 0, 0, HLT, 0);  check("halt_hold", v1, O_ACK);

    // Restart from HALT, then ldb / stb / jump taken / jump not taken / halt.
    cyc(0, 1, 0, HLT, 0);  check("restart", v1, O_PCI | O_ACK);
    cyc(0, 0, 0, LDB, 0);  check("rs_fetch_ackdrop", v1, O_IRL);
    check("rs_cyc_clear", cyc1, 16'd0);
    check("rs_ins_clear", ins1, 16'd0);
    cyc(0, 1, 0, LDB, 0);  check("exec_start_ignored", v1, O_NONE);
    cyc(0, 0, 0, LDB, 0);  check("ldb_mem", v1, O_RD);
    cyc(0, 0, 0, LDB, 0);  check("ldb_wb", v1, O_WBR);
    cyc(0, 0, 0, STB, 0);  check("stb_fetch", v1, O_IRL);
    cyc(0, 0, 0, STB, 0);  check("stb_exec", v1, O_NONE);
    cyc(0, 0, 0, STB, 0);  check("stb_mem", v1, O_WR);
    cyc(0, 0, 0, STB, 1);  check("stb_wb", v1, O_WBN);
    cyc(0, 0, 0, JMP, 0);  check("jmp1_fetch", v1, O_IRL);
    cyc(0, 0, 0, JMP, 0);  check("jmp1_exec", v1, O_NONE);
    cyc(0, 0, 0, JMP, 1);  check("jmp_taken_wb", v1, O_WBJ);
    cyc(0, 0, 0, JMP, 0);  check("jmp2_fetch", v1, O_IRL);
    cyc(0, 0, 0, JMP, 0);  check("jmp2_exec", v1, O_NONE);
    cyc(0, 0, 0, JMP, 0);  check("jmp_nt_wb", v1, O_WBN);
    cyc(0, 0, 0, HLT, 0);  check("h2_fetch", v1, O_IRL);
    cyc(0, 0, 0, HLT, 0);  check("h2_exec", v1, O_NONE);
    cyc(0, 0, 0, HLT, 0);  check("h2_halt", v1, O_ACK);
    check("run2_cyc", cyc1, PERF ? 16'd16 : 16'd0);
    check("run2_ins", ins1, PERF ? 16'd5 : 16'd0);

    // ldb with MEM_LAT=3 on dut3.
    cyc(0, 0, 1, HLT, 0);  check("l3_pcinit", v3, O_PCI);
    cyc(0, 0, 0, LDB, 0);  check("l3_fetch", v3, O_IRL);
    cyc(0, 0, 0, LDB, 0);  check("l3_exec", v3, O_NONE);
    cyc(0, 0, 0, LDB, 0);  check("l3_mem0", v3, O_RD);
    cyc(0, 0, 0, LDB, 0);  check("l3_mem1", v3, O_RD);
    cyc(0, 0, 0, LDB, 0);  check("l3_mem2", v3, O_RD);
    cyc(0, 0, 0, LDB, 0);  check("l3_wb", v3, O_WBR);
    cyc(0, 0, 0, LDB, 0);  check("l3_next_fetch", v3, O_IRL);
    check("l3_cyc", cyc3, PERF ? 16'd6 : 16'd0);
    check("l3_ins", ins3, PERF ? 16'd1 : 16'd0);
    cyc(0, 0, 0, LDB, 0);  check("l3b_exec", v3, O_NONE);
    cyc(0, 0, 0, LDB, 0);  check("l3b_mem0", v3, O_RD);

    // Reset held two cycles in the middle of MEM.
    cyc(1, 0, 0, LDB, 0);
    cyc(1, 0, 0, LDB, 0);
    check("midmem_rst_out3", v3, O_NONE);
    check("midmem_rst_out1", v1, O_NONE);
    check("midmem_rst_cyc3", cyc3, 16'd0);
    check("midmem_rst_ins3", ins3, 16'd0);
    cyc(0, 0, 0, LDB, 0);
    check("rst_release3", v3, O_NONE);
    check("rst_release1", v1, O_NONE);
    cyc(0, 0, 0, LDB, 0);
    check("rst_idle3", v3, O_NONE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
